// File: rtl/brq_pkg.sv
// brq_pkg: entry layout, BHT counter encodings and the mispredict rule shared by
// the branch resolve queue and its storage FIFO.
package brq_pkg;
    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [1:0]  ctr;
    } brq_entry_t;

    localparam int ENTRY_W = $bits(brq_entry_t);

    // A taken branch is only correct if the fetch-time target also matched.
    function automatic logic mispredicted(input brq_entry_t e, input logic taken,
                                          input logic [31:0] target);
        return (taken != e.pred_taken) || (taken && (target != e.pred_target));
    endfunction
endpackage

// File: rtl/brq_fifo.sv
// brq_fifo: circular buffer of in-flight branch entries with occupancy count;
// clear empties the queue and wins over a same-cycle push or pop.
module brq_fifo
    import brq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic                     pop,
    input  logic                     clear,
    output logic [ENTRY_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;

    assign rdata = mem[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[tail] <= wdata;
    end
endmodule

// File: rtl/br_resolve_queue.sv
// br_resolve_queue: in-order queue of fetch-time branch predictions, resolved by EX;
// drives BTB update and fetch redirect/flush. Define BRQ_STATS_EN for branch/mispredict counters.
module br_resolve_queue
    import brq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [31:0]            enq_pc,
    input  logic                   enq_pred_taken,
    input  logic [31:0]            enq_pred_target,
    input  logic [1:0]             enq_ctr,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic [31:0]            res_target,
    output logic                   upd_valid,
    output logic [31:0]            upd_pc,
    output logic [1:0]             upd_ctr_ret,
    output logic                   upd_mispredict,
    output logic [31:0]            upd_target,
    output logic                   flush,
    output logic [31:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   res_err
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispred
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    brq_entry_t         enq_e;
    brq_entry_t         head_e;
    logic [ENTRY_W-1:0] head_bits;
    logic               res_fire;
    logic               mis;
    logic               clear;

    assign enq_e     = '{pc: enq_pc, pred_taken: enq_pred_taken,
                         pred_target: enq_pred_target, ctr: enq_ctr};
    assign head_e    = head_bits;
    // No pop bypass; while flush is out, fetch is stale and nothing is taken in.
    assign enq_ready = (count != CW'(DEPTH)) && !flush;
    assign res_fire  = res_valid && (count != '0);
    assign mis       = mispredicted(head_e, res_taken, res_target);
    assign clear     = res_fire && mis;

    brq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (enq_valid && enq_ready && !clear),
        .wdata (enq_e),
        .pop   (res_fire),
        .clear (clear),
        .rdata (head_bits),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_ctr_ret    <= '0;
            upd_mispredict <= 1'b0;
            upd_target     <= '0;
            flush          <= 1'b0;
            redirect_pc    <= '0;
            res_err        <= 1'b0;
        end else begin
            upd_valid <= res_fire;
            flush     <= clear;
            if (res_valid && count == '0) res_err <= 1'b1;
            if (res_fire) begin
                upd_pc         <= head_e.pc;
                upd_ctr_ret    <= head_e.ctr;
                upd_mispredict <= mis;
                upd_target     <= res_target;
                redirect_pc    <= res_taken ? res_target : head_e.pc + 32'd4;
            end
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (upd_valid) stat_branches <= stat_branches + 32'd1;
            if (upd_valid && upd_mispredict) stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_br_resolve_queue.sv
// tb_br_resolve_queue: directed and random stimulus against a queue-based reference model;
// expected BTB updates are scoreboarded and checked by a separate negedge monitor.
module tb_br_resolve_queue;
    localparam int DEPTH = 4;

    typedef struct {
        int          due;
        logic [31:0] pc;
        logic [1:0]  ctr;
        logic [31:0] target;
        logic        mis;
        logic [31:0] redirect;
    } upd_t;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic [1:0]  ctr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enq_valid = 1'b0, enq_pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
    logic [31:0] enq_pc = '0, enq_pred_target = '0, res_target = '0;
    logic [1:0]  enq_ctr = '0;
    logic        enq_ready, upd_valid, upd_mispredict, flush, res_err;
    logic [31:0] upd_pc, upd_target, redirect_pc;
    logic [1:0]  upd_ctr_ret;
    logic [2:0]  count;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ent_t mq[$];
    upd_t exp_q[$];
    logic flush_m = 1'b0;
    logic err_m = 1'b0;

    br_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .enq_valid       (enq_valid),
        .enq_ready       (enq_ready),
        .enq_pc          (enq_pc),
        .enq_pred_taken  (enq_pred_taken),
        .enq_pred_target (enq_pred_target),
        .enq_ctr         (enq_ctr),
        .res_valid       (res_valid),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_ctr_ret     (upd_ctr_ret),
        .upd_mispredict  (upd_mispredict),
        .upd_target      (upd_target),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .count           (count),
        .res_err         (res_err)
`ifdef BRQ_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: an update is due exactly one cycle after its pop.
    always @(negedge clk) begin : mon
        upd_t u;
        if (rst) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                u = exp_q.pop_front();
                check("upd_valid", 32'(upd_valid), 32'd1);
                check("upd_pc", upd_pc, u.pc);
                check("upd_ctr_ret", 32'(upd_ctr_ret), 32'(u.ctr));
                check("upd_target", upd_target, u.target);
                check("upd_mispredict", 32'(upd_mispredict), 32'(u.mis));
                check("flush", 32'(flush), 32'(u.mis));
                if (u.mis) check("redirect_pc", redirect_pc, u.redirect);
            end else begin
                check("idle_upd_flush", 32'({upd_valid, flush}), 32'd0);
            end
        end
    end

    // Drive one cycle of stimulus, advance the model, then check state after the edge.
    task automatic step(input logic ev, input logic [31:0] pc, input logic pt,
                        input logic [31:0] tgt, input logic [1:0] ctr,
                        input logic rv, input logic rt, input logic [31:0] rtgt);
        logic ready;
        logic mis;
        ent_t e;
        enq_valid = ev; enq_pc = pc; enq_pred_taken = pt; enq_pred_target = tgt; enq_ctr = ctr;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        ready = (mq.size() < DEPTH) && !flush_m;
        mis = 1'b0;
        if (rv && mq.size() == 0) err_m = 1'b1;
        if (rv && mq.size() != 0) begin
            e = mq.pop_front();
            mis = (rt != e.pt) || (rt && rtgt != e.tgt);
            exp_q.push_back('{cyc + 1, e.pc, e.ctr, rtgt, mis, rt ? rtgt : e.pc + 32'd4});
            if (mis) mq.delete();
        end
        if (ev && ready && !mis) mq.push_back('{pc, pt, tgt, ctr});
        flush_m = mis;
        @(posedge clk);
        #1;
        enq_valid = 1'b0;
        res_valid = 1'b0;
        check("count", 32'(count), 32'(mq.size()));
        check("enq_ready", 32'(enq_ready), 32'((mq.size() < DEPTH) && !flush_m));
        check("res_err", 32'(res_err), 32'(err_m));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 2'b00, 1'b0, 1'b0, '0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_enq_ready", 32'(enq_ready), 32'd1);
        check("rst_upd_valid", 32'(upd_valid), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        rst = 1'b1;

        // Correct prediction
        step(1'b1, 32'h100, 1'b1, 32'h200, 2'b11, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0, 2'b00, 1'b1, 1'b1, 32'h200);
        check("t1_upd_valid", 32'(upd_valid), 32'd1);
        check("t1_mispredict", 32'(upd_mispredict), 32'd0);
        check("t1_flush", 32'(flush), 32'd0);
        check("t1_count", 32'(count), 32'd0);

        // Direction miss
        step(1'b1, 32'h40, 1'b0, 32'h0, 2'b01, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0, 2'b00, 1'b1, 1'b1, 32'h80);
        check("t2_mispredict", 32'(upd_mispredict), 32'd1);
        check("t2_flush", 32'(flush), 32'd1);
        check("t2_redirect", redirect_pc, 32'h80);
        check("t2_ctr_ret", 32'(upd_ctr_ret), 32'd1);
        idle();

        // Target miss
        step(1'b1, 32'h500, 1'b1, 32'h300, 2'b10, 1'b0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0, 2'b00, 1'b1, 1'b1, 32'h304);
        check("t3_mispredict", 32'(upd_mispredict), 32'd1);
        check("t3_redirect", redirect_pc, 32'h304);
        idle();

        // Fill, then a refused enqueue alongside a pop
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 32'h2000, 2'b11, 1'b0, 1'b0, '0);
        check("t4_full_ready", 32'(enq_ready), 32'd0);
        step(1'b1, 32'h9990, 1'b1, 32'h2000, 2'b11, 1'b1, 1'b1, 32'h2000);
        check("t4_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, '0, 2'b00, 1'b1, 1'b1, 32'h2000);

        // Head mispredict at top of address space with a same-cycle enqueue
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 2'b10, 1'b0, 1'b0, '0);
        step(1'b1, 32'h600, 1'b0, 32'h0, 2'b01, 1'b0, 1'b0, '0);
        step(1'b1, 32'h604, 1'b0, 32'h0, 2'b01, 1'b0, 1'b0, '0);
        step(1'b1, 32'hAAA0, 1'b0, 32'h0, 2'b01, 1'b1, 1'b0, 32'h50);
        check("t5_redirect", redirect_pc, 32'h0);
        check("t5_count", 32'(count), 32'd0);
        idle();
        check("t5_dropped", 32'(count), 32'd0);

        // Resolve while empty
        step(1'b0, '0, 1'b0, '0, 2'b00, 1'b1, 1'b1, 32'h44);
        check("t6_res_err", 32'(res_err), 32'd1);
        check("t6_upd_valid", 32'(upd_valid), 32'd0);

        // Asynchronous reset mid-fill with an update in flight
        step(1'b1, 32'h700, 1'b1, 32'h800, 2'b11, 1'b0, 1'b0, '0);
        step(1'b1, 32'h704, 1'b1, 32'h800, 2'b11, 1'b1, 1'b1, 32'h800);
        rst = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_upd_valid", 32'(upd_valid), 32'd0);
        check("arst_res_err", 32'(res_err), 32'd0);
        mq.delete();
        exp_q.delete();
        flush_m = 1'b0;
        err_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 32'h100 + 32'(4 * $urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)),
                 32'h100 + 32'(4 * $urandom_range(0, 1)));
        idle();
        idle();
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
